can_rx_drain: RTL and testbench
===============================

# can_rx_drain

Receive-side bus initiator that sits between the CPU peripheral port and the CAN controller's 4-register interface (ID, DLC/flags, DATA0, DATA1). It polls the controller's DLC/flags register, and when a valid frame is flagged it reads the frame out in an atomic burst and pushes it into a small FIFO. The CPU dequeues whole frames from the FIFO instead of racing the controller's single receive buffer. All other CPU accesses, including TX setup writes, pass through to the controller when the engine is not bursting.

## Interface
- DEPTH, 4: FIFO entries; must be a power of 2, 2..16.
- POLL_DIV, 64: idle clocks between polls, range 1..1023.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  engine enable; 0 = no polls, FIFO retained.
- cpu_cs  in  1  CPU access strobe to the controller.
- cpu_rs  in  2  CPU register select.
- cpu_bytesel  in  4  CPU write lanes; 0000 = read.
- cpu_d  in  32  CPU write data.
- cpu_ready  out  1  CPU access accepted this cycle.
- can_cs  out  1  chip select to the controller.
- can_rs  out  2  register select to the controller.
- can_bytesel  out  4  byte lanes to the controller.
- can_d  out  32  write data to the controller.
- can_q  in  32  controller read data, combinational from cs/rs.
- cpu_q  out  32  equals can_q.
- frame_valid  out  1  FIFO not empty.
- frame_id  out  32  head entry: ID word ({ext[31], rtr[30], 0, id[28:0]}).
- frame_ctl  out  16  head entry: flags word bits [15:0] (ackf 11, bitf 10, lostf 9, rts 8, ovwr 7, frmav 6, crcerr 5, stufferr 4, dlc 3:0).
- frame_d0  out  32  head entry: DATA0 word.
- frame_d1  out  32  head entry: DATA1 word.
- frame_pop  in  1  dequeue head; ignored when empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- irq  out  1  en & frame_valid.

## Operation
- States: WAIT, POLL, RD0, RD1, RDID.
- WAIT: poll counter counts down from POLL_DIV. At 0 with en=1 and cpu_cs=0, go to POLL. If cpu_cs=1 the poll is deferred; the counter holds at 0.
- The CPU owns the bus only in WAIT: can_* = cpu_*, and cpu_ready = cpu_cs. In all other states cpu_ready=0 and the CPU must hold its request.
- Engine reads drive can_cs=1, can_bytesel=0000, can_d=0. can_q is captured on the same clock edge.
- POLL: rs=01, capture ctl=can_q[15:0].
  - If ctl[6] (frmav)=1 and FIFO not full, go to RD0.
  - Otherwise go to WAIT, counter reloaded.
  - A full FIFO leaves the frame in the controller; the controller's ovwr marks any loss. It is reported in the ctl of the next captured frame.
- RD0: rs=10, capture d0.
- RD1: rs=11, capture d1.
- RDID: rs=00 with bytesel 0000. This read clears the controller's frmav, ovwr, crcerr and stufferr, so ID is always read last. Push {id=can_q, ctl, d0, d1} on this edge, then go to WAIT with the counter reloaded.
- A burst is 4 consecutive cycles and is never interrupted except by reset.
- FIFO: circular with rd/wr pointers and count. frame_* show the head combinationally from storage.
  - Pop when empty is ignored.
  - Push and pop in the same cycle leave level unchanged. This is legal even when full, because push is only reached after a not-full check and pop only frees space.
- en=0: WAIT holds the counter at POLL_DIV. An in-progress burst completes. Pass-through still works.
- The CPU must not read the ID register while en=1. Doing so steals the frame; this is a software rule and is not checked by the block.

## Timing
- Reset values:
  - State WAIT, counter POLL_DIV, FIFO empty, level 0.
  - frame_valid=0, irq=0, cpu_ready=0.
  - can_cs=0, can_rs=0, can_bytesel=0, can_d=0.
  - frame_* outputs are 0 (storage cleared).
- Reset mid-burst abandons the burst. The frame remains in the controller because ID was not yet read, and it is re-read after the next poll.
- Poll-to-push latency is 4 clocks (POLL, RD0, RD1, RDID). frame_valid rises the cycle after RDID.
- Poll period is POLL_DIV+1 clocks when the frame is unavailable and POLL_DIV+4 clocks after a drain. Deferral by CPU accesses extends it.
- frame_pop takes effect on the edge; the new head is visible the next cycle.

## Test plan
- Reset check: assert reset for 3 cycles -> all outputs at reset values, can_cs=0. After POLL_DIV clocks, exactly one POLL cycle with can_rs=01 and can_bytesel=0000.
- Single frame drain: model returns ctl=0x0048 (frmav, dlc=8), d0=0x11223344, d1=0x55667788, id=0x00000123 -> can_rs sequence 01,10,11,00 on consecutive cycles. Then frame_valid=1, frame_id=0x123, frame_ctl=0x0048, frame_d1=0x55667788. Model frmav clears after the ID read.
- FIFO full: push DEPTH frames without popping -> level=DEPTH; next poll sees frmav=1 and returns to WAIT with no RD0. Pop one entry -> next poll drains, and its ctl shows ovwr=1 if the model set it.
- CPU contention: cpu_cs=1, cpu_rs=01, cpu_bytesel=0011, cpu_d=0x108 issued during RD1 -> cpu_ready=0 until WAIT, then forwarded unchanged for one cycle with cpu_ready=1.
- Simultaneous push/pop: frame_pop=1 in the RDID cycle with level=2 -> level stays 2 and the head advances.
- Reset asserted in the RD1 cycle -> FIFO empty, and a later poll drains the same frame exactly once.

Source files
------------

// File: rtl/can_rx_drain_if.sv
// can_rx_drain bus bundle: CPU peripheral port and CAN controller register port.
// slave = drain engine side, master = CPU/controller environment side.
interface can_rx_drain_if;
    logic        cpu_cs;
    logic [1:0]  cpu_rs;
    logic [3:0]  cpu_bytesel;
    logic [31:0] cpu_d;
    logic        cpu_ready;
    logic [31:0] cpu_q;
    logic        can_cs;
    logic [1:0]  can_rs;
    logic [3:0]  can_bytesel;
    logic [31:0] can_d;
    logic [31:0] can_q;

    modport slave (
        input  cpu_cs, cpu_rs, cpu_bytesel, cpu_d, can_q,
        output cpu_ready, cpu_q, can_cs, can_rs, can_bytesel, can_d
    );

    modport master (
        output cpu_cs, cpu_rs, cpu_bytesel, cpu_d, can_q,
        input  cpu_ready, cpu_q, can_cs, can_rs, can_bytesel, can_d
    );
endinterface

// File: rtl/can_rx_drain.sv
// CAN receive drain: polls the controller DLC/flags register, bursts whole
// frames (DLC, DATA0, DATA1, ID last) into a FIFO the CPU dequeues.
// Ports: clk, reset (async, active-high), en, bus (CPU/CAN register bundle),
//   frame_valid/id/ctl/d0/d1 (FIFO head), frame_pop, level, irq.
module can_rx_drain #(
    parameter int DEPTH    = 4,
    parameter int POLL_DIV = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    can_rx_drain_if.slave              bus,
    output logic                       frame_valid,
    output logic [31:0]                frame_id,
    output logic [15:0]                frame_ctl,
    output logic [31:0]                frame_d0,
    output logic [31:0]                frame_d1,
    input  logic                       frame_pop,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 10;
    localparam logic [CW-1:0] RELOAD   = CW'(POLL_DIV);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [2:0] {
        WAIT,
        POLL,
        RD0,
        RD1,
        RDID
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   ctl_r;
    logic [31:0]   d0_r;
    logic [31:0]   d1_r;

    logic [31:0]   mem_id  [DEPTH];
    logic [15:0]   mem_ctl [DEPTH];
    logic [31:0]   mem_d0  [DEPTH];
    logic [31:0]   mem_d1  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic full;
    logic push;
    logic pop;

    assign full = (count == FULL_LVL);
    assign push = (state == RDID);
    assign pop  = frame_pop && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= WAIT;
            cnt    <= RELOAD;
            ctl_r  <= '0;
            d0_r   <= '0;
            d1_r   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_id[i]  <= '0;
                mem_ctl[i] <= '0;
                mem_d0[i]  <= '0;
                mem_d1[i]  <= '0;
            end
        end else begin
            unique case (state)
                WAIT: begin
                    // The edge that would bring the counter to 0 starts the
                    // poll, giving exactly POLL_DIV idle clocks between polls.
                    if (!en) begin
                        cnt <= RELOAD;
                    end else if (cnt > CW'(1)) begin
                        cnt <= cnt - 1'b1;
                    end else if (bus.cpu_cs) begin
                        cnt <= '0;
                    end else begin
                        state <= POLL;
                    end
                end
                POLL: begin
                    ctl_r <= bus.can_q[15:0];
                    if (bus.can_q[6] && !full) begin
                        state <= RD0;
                    end else begin
                        state <= WAIT;
                        cnt   <= RELOAD;
                    end
                end
                RD0: begin
                    d0_r  <= bus.can_q;
                    state <= RD1;
                end
                RD1: begin
                    d1_r  <= bus.can_q;
                    state <= RDID;
                end
                RDID: begin
                    state <= WAIT;
                    cnt   <= RELOAD;
                end
                default: begin
                    state <= WAIT;
                    cnt   <= RELOAD;
                end
            endcase

            // ID is read last because that read clears the controller flags.
            if (push) begin
                mem_id[wr_ptr]  <= bus.can_q;
                mem_ctl[wr_ptr] <= ctl_r;
                mem_d0[wr_ptr]  <= d0_r;
                mem_d1[wr_ptr]  <= d1_r;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        bus.can_cs      = 1'b1;
        bus.can_rs      = 2'b00;
        bus.can_bytesel = 4'b0000;
        bus.can_d       = '0;
        bus.cpu_ready   = 1'b0;
        unique case (state)
            WAIT: begin
                bus.can_cs      = bus.cpu_cs;
                bus.can_rs      = bus.cpu_rs;
                bus.can_bytesel = bus.cpu_bytesel;
                bus.can_d       = bus.cpu_d;
                bus.cpu_ready   = bus.cpu_cs;
            end
            POLL:    bus.can_rs = 2'b01;
            RD0:     bus.can_rs = 2'b10;
            RD1:     bus.can_rs = 2'b11;
            default: bus.can_rs = 2'b00;
        endcase
    end

    assign bus.cpu_q   = bus.can_q;
    assign frame_valid = (count != '0);
    assign frame_id    = mem_id[rd_ptr];
    assign frame_ctl   = mem_ctl[rd_ptr];
    assign frame_d0    = mem_d0[rd_ptr];
    assign frame_d1    = mem_d1[rd_ptr];
    assign level       = count;
    assign irq         = en && frame_valid;
endmodule

// File: tb/tb_can_rx_drain.sv
// Bench for can_rx_drain: behavioural CAN controller, queue-based frame model,
// directed and random frames, immediate-assertion checks.
module tb_can_rx_drain;
    localparam int DEPTH = 4;
    localparam int PDIV  = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] id;
        logic [15:0] ctl;
        logic [31:0] d0;
        logic [31:0] d1;
    } frm_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          frame_pop;
    logic          frame_valid;
    logic [31:0]   frame_id;
    logic [15:0]   frame_ctl;
    logic [31:0]   frame_d0;
    logic [31:0]   frame_d1;
    logic [LW-1:0] level;
    logic          irq;

    can_rx_drain_if bus();

    can_rx_drain #(.DEPTH(DEPTH), .POLL_DIV(PDIV)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .bus(bus),
        .frame_valid(frame_valid),
        .frame_id(frame_id),
        .frame_ctl(frame_ctl),
        .frame_d0(frame_d0),
        .frame_d1(frame_d1),
        .frame_pop(frame_pop),
        .level(level),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Controller model: one receive buffer with frmav/ovwr flags.
    logic        dlv_req = 1'b0;
    logic [31:0] dlv_id = '0;
    logic [31:0] dlv_d0 = '0;
    logic [31:0] dlv_d1 = '0;
    logic [15:0] dlv_flags = '0;
    logic        m_avail = 1'b0;
    logic        m_ovwr = 1'b0;
    logic [15:0] m_flags = '0;
    logic [31:0] m_id = '0;
    logic [31:0] m_d0 = '0;
    logic [31:0] m_d1 = '0;
    logic [15:0] m_ctl;

    assign m_ctl = {m_flags[15:8], m_ovwr, m_avail, m_flags[5:0]};

    always_comb begin
        case (bus.can_rs)
            2'b00:   bus.can_q = m_id;
            2'b01:   bus.can_q = {16'h0000, m_ctl};
            2'b10:   bus.can_q = m_d0;
            default: bus.can_q = m_d1;
        endcase
    end

    always @(posedge clk) begin
        if (dlv_req) begin
            m_ovwr  <= m_avail | m_ovwr;
            m_avail <= 1'b1;
            m_flags <= dlv_flags;
            m_id    <= dlv_id;
            m_d0    <= dlv_d0;
            m_d1    <= dlv_d1;
        end else if (bus.can_cs && bus.can_rs == 2'b00 &&
                     bus.can_bytesel == 4'b0000) begin
            m_avail    <= 1'b0;
            m_ovwr     <= 1'b0;
            m_flags[5] <= 1'b0;
            m_flags[4] <= 1'b0;
        end
    end

    int   total = 0;
    int   bad = 0;
    frm_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_poll(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.can_cs && n < 2000);
        chk("poll_seen", 32'(bus.can_cs), 1);
    endtask

    task automatic wait_level(input int target, input string tag);
        int n;
        n = 0;
        while (int'(level) != target && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(level), 32'(target));
    endtask

    task automatic send(input logic [31:0] id, input logic [15:0] flags,
                        input logic [31:0] d0, input logic [31:0] d1,
                        output frm_t f);
        f.id  = id;
        f.d0  = d0;
        f.d1  = d1;
        f.ctl = (flags & 16'hFF3F) | 16'h0040 |
                ((m_avail || m_ovwr) ? 16'h0080 : 16'h0000);
        dlv_id    = id;
        dlv_flags = flags & 16'hFF3F;
        dlv_d0    = d0;
        dlv_d1    = d1;
        dlv_req   = 1'b1;
        step();
        dlv_req   = 1'b0;
    endtask

    task automatic send_rand(output frm_t f);
        logic [15:0] fl;
        fl      = 16'($urandom);
        fl[3:0] = 4'($urandom_range(0, 8));
        send($urandom & 32'hDFFF_FFFF, fl, $urandom, $urandom, f);
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_valid"}, 32'(frame_valid), 1);
        chk({tag, "_id"}, frame_id, exp_q[0].id);
        chk({tag, "_ctl"}, 32'(frame_ctl), 32'(exp_q[0].ctl));
        chk({tag, "_d0"}, frame_d0, exp_q[0].d0);
        chk({tag, "_d1"}, frame_d1, exp_q[0].d1);
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        frame_pop = 1'b1;
        step();
        frame_pop = 1'b0;
        void'(exp_q.pop_front());
        chk({tag, "_lvl"}, 32'(level), 32'(exp_q.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   seen;
        frm_t f;
        frm_t fx;
        frm_t fy;

        reset           = 1'b1;
        en              = 1'b1;
        frame_pop       = 1'b0;
        bus.cpu_cs      = 1'b0;
        bus.cpu_rs      = 2'b00;
        bus.cpu_bytesel = 4'b0000;
        bus.cpu_d       = '0;
        repeat (3) step();

        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ready", 32'(bus.cpu_ready), 0);
        chk("rst_can_cs", 32'(bus.can_cs), 0);
        chk("rst_can_rs", 32'(bus.can_rs), 0);
        chk("rst_bytesel", 32'(bus.can_bytesel), 0);
        chk("rst_can_d", bus.can_d, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_id", frame_id, 0);
        chk("rst_ctl", 32'(frame_ctl), 0);
        chk("rst_d0", frame_d0, 0);
        chk("rst_d1", frame_d1, 0);
        reset = 1'b0;

        wait_poll(n);
        chk("first_poll_dly", 32'(n), PDIV);
        chk("poll_rs", 32'(bus.can_rs), 1);
        chk("poll_bytesel", 32'(bus.can_bytesel), 0);
        chk("poll_d", bus.can_d, 0);
        step();
        chk("idle_no_rd0", 32'(bus.can_cs), 0);
        wait_poll(n);
        chk("idle_period", 32'(n + 1), PDIV + 1);

        send(32'h0000_0123, 16'h0008, 32'h1122_3344, 32'h5566_7788, f);
        exp_q.push_back(f);
        wait_poll(n);
        chk("seq_rs0", 32'(bus.can_rs), 1);
        step();
        chk("seq_rs1", 32'(bus.can_rs), 2);
        step();
        chk("seq_rs2", 32'(bus.can_rs), 3);
        step();
        chk("seq_rs3", 32'(bus.can_rs), 0);
        chk("seq_rs3_cs", 32'(bus.can_cs), 1);
        chk("seq_rs3_bs", 32'(bus.can_bytesel), 0);
        chk("seq_pre_valid", 32'(frame_valid), 0);
        step();
        chk("single_level", 32'(level), 1);
        chk("single_irq", 32'(irq), 1);
        chk("single_ctl_lit", 32'(frame_ctl), 32'h0048);
        check_head("single");
        chk("ctrl_cleared", 32'(m_avail), 0);
        wait_poll(n);
        chk("drain_period", 32'(n + 4), PDIV + 4);
        pop_one("single_pop");
        chk("empty_valid", 32'(frame_valid), 0);

        for (int i = 0; i < DEPTH; i++) begin
            send_rand(f);
            exp_q.push_back(f);
            wait_level(i + 1, "fill_lvl");
        end
        send_rand(fx);
        send_rand(fy);
        chk("ovwr_expected", 32'(fy.ctl[7]), 1);
        wait_poll(n);
        step();
        chk("full_no_rd0", 32'(bus.can_cs), 0);
        chk("full_level", 32'(level), DEPTH);
        chk("full_kept", 32'(m_avail), 1);
        pop_one("full_pop");
        exp_q.push_back(fy);
        wait_level(DEPTH, "refill_lvl");
        while (exp_q.size() > 0) pop_one("drain_full");

        send_rand(f);
        exp_q.push_back(f);
        wait_poll(n);
        step();
        step();
        bus.cpu_cs      = 1'b1;
        bus.cpu_rs      = 2'b01;
        bus.cpu_bytesel = 4'b0011;
        bus.cpu_d       = 32'h0000_0108;
        #1;
        chk("cont_rd1_ready", 32'(bus.cpu_ready), 0);
        chk("cont_rd1_rs", 32'(bus.can_rs), 3);
        step();
        chk("cont_rdid_ready", 32'(bus.cpu_ready), 0);
        chk("cont_rdid_rs", 32'(bus.can_rs), 0);
        chk("cont_rdid_bs", 32'(bus.can_bytesel), 0);
        chk("cont_rdid_d", bus.can_d, 0);
        step();
        chk("cont_wait_ready", 32'(bus.cpu_ready), 1);
        chk("cont_wait_cs", 32'(bus.can_cs), 1);
        chk("cont_wait_rs", 32'(bus.can_rs), 1);
        chk("cont_wait_bs", 32'(bus.can_bytesel), 4'b0011);
        chk("cont_wait_d", bus.can_d, 32'h0000_0108);
        chk("cont_cpu_q", bus.cpu_q, {16'h0000, f.ctl & 16'hFF0F});
        bus.cpu_cs      = 1'b0;
        bus.cpu_rs      = 2'b00;
        bus.cpu_bytesel = 4'b0000;
        bus.cpu_d       = '0;
        chk("cont_level", 32'(level), 1);
        check_head("cont");

        send_rand(f);
        exp_q.push_back(f);
        wait_level(2, "pp_pre_lvl");
        send_rand(f);
        wait_poll(n);
        step();
        step();
        step();
        chk("pp_rdid", 32'(bus.can_rs), 0);
        frame_pop = 1'b1;
        step();
        frame_pop = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(f);
        chk("pp_level", 32'(level), 2);
        check_head("pp_head");

        en = 1'b0;
        #1;
        chk("en0_irq", 32'(irq), 0);
        chk("en0_valid", 32'(frame_valid), 1);
        send_rand(f);
        exp_q.push_back(f);
        seen = 0;
        repeat (3 * PDIV) begin
            step();
            if (bus.can_cs) seen++;
        end
        chk("en0_nopoll", 32'(seen), 0);
        chk("en0_level", 32'(level), 2);
        en = 1'b1;
        wait_level(3, "en1_lvl");
        chk("en1_irq", 32'(irq), 1);
        while (exp_q.size() > 0) pop_one("drain_en");

        send_rand(f);
        wait_poll(n);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rrst_level", 32'(level), 0);
        chk("rrst_valid", 32'(frame_valid), 0);
        chk("rrst_cs", 32'(bus.can_cs), 0);
        step();
        reset = 1'b0;
        chk("rrst_ctrl_kept", 32'(m_avail), 1);
        exp_q.delete();
        exp_q.push_back(f);
        wait_level(1, "rrst_lvl");
        check_head("rrst_frame");
        repeat (3 * PDIV) step();
        chk("rrst_once", 32'(level), 1);
        pop_one("rrst_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
